// File: rtl/sdff_asr_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : sdff_asr_bank_if
// Description : Bundle of the scan/functional data path of sdff_asr_bank.
//               master drives SE, EN, D, SI; slave (the register bank)
//               returns Q, QN, SO, SHIFT_DONE.
// Ports       : SE         scan enable
//               EN         functional load enable (used when SE=0)
//               D          functional data, WIDTH bits
//               SI         scan in, one bit per segment
//               Q / QN     register value and complement output
//               SO         scan out, top bit of each segment
//               SHIFT_DONE one-cycle pulse after a full segment shift
// Revision    : 1.0 - initial release
// ============================================================================
interface sdff_asr_bank_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_CHAINS = 1
);
    logic                  SE;
    logic                  EN;
    logic [WIDTH-1:0]      D;
    logic [NUM_CHAINS-1:0] SI;
    logic [WIDTH-1:0]      Q;
    logic [WIDTH-1:0]      QN;
    logic [NUM_CHAINS-1:0] SO;
    logic                  SHIFT_DONE;

    modport master (output SE, EN, D, SI, input Q, QN, SO, SHIFT_DONE);
    modport slave  (input SE, EN, D, SI, output Q, QN, SO, SHIFT_DONE);
endinterface
`default_nettype wire

// File: rtl/sdff_asr_bank.sv
`default_nettype none
// ============================================================================
// Module      : sdff_asr_bank
// Description : WIDTH-bit mux-scan register bank with asynchronous active-low
//               reset (RSTB) and per-bit masked asynchronous set (SETB).
//               The bank is cut into NUM_CHAINS scan segments of
//               L = WIDTH/NUM_CHAINS bits; a shift counter pulses SHIFT_DONE
//               every L consecutive shift edges.
// Ports       : CLK   rising-edge clock
//               RSTB  async active-low reset (Q=0, QN=1, counter cleared)
//               SETB  async active-low set, only on bits with SET_MASK=1
//               bus   sdff_asr_bank_if slave: SE, EN, D, SI in;
//                     Q, QN, SO, SHIFT_DONE out
// Revision    : 1.0 - initial release
// ============================================================================
module sdff_asr_bank #(
    parameter int               WIDTH      = 8,
    parameter int               NUM_CHAINS = 1,
    parameter logic [WIDTH-1:0] SET_MASK   = '1
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          SETB,
    sdff_asr_bank_if.slave bus
);

    localparam int                 c_SEG_LEN  = WIDTH / NUM_CHAINS;
    localparam int                 c_CNT_W    = $clog2(c_SEG_LEN) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_SEG_LEN - 1);

    logic [WIDTH-1:0]      w_q;
    logic [WIDTH-1:0]      w_qn;
    logic [NUM_CHAINS-1:0] w_so;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_shift_done;

    // ------------------------------------------------------------------
    // One flop per bit so that only bits with SET_MASK=1 get the async
    // set pin; unmasked bits never see SETB at all.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_shift_in;
        logic w_nxt;
        logic r_bit;

        // Segment head takes the scan input, every other bit its lower
        // neighbour within the same segment.
        if ((i % c_SEG_LEN) == 0) begin : g_head
            assign w_shift_in = bus.SI[i / c_SEG_LEN];
        end else begin : g_body
            assign w_shift_in = w_q[i-1];
        end

        assign w_nxt = bus.SE ? w_shift_in : (bus.EN ? bus.D[i] : r_bit);

        if (SET_MASK[i]) begin : g_set
            always_ff @(posedge CLK or negedge RSTB or negedge SETB) begin
                if (!RSTB) begin
                    r_bit <= 1'b0;
                end else if (!SETB) begin
                    r_bit <= 1'b1;
                end else begin
                    r_bit <= w_nxt;
                end
            end
            // QN is its own value while an async control is active (both
            // low gives Q=0 and QN=0); once released it tracks ~Q, which
            // is the re-sync on deassertion.
            assign w_qn[i] = !SETB ? 1'b0 : (!RSTB ? 1'b1 : ~r_bit);
        end else begin : g_noset
            always_ff @(posedge CLK or negedge RSTB) begin
                if (!RSTB) begin
                    r_bit <= 1'b0;
                end else begin
                    r_bit <= w_nxt;
                end
            end
            assign w_qn[i] = !RSTB ? 1'b1 : ~r_bit;
        end

        assign w_q[i] = r_bit;
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_so
        assign w_so[c] = w_q[c*c_SEG_LEN + c_SEG_LEN - 1];
    end

    // ------------------------------------------------------------------
    // Shift counter: counts consecutive shift edges modulo L. Only RSTB
    // clears it asynchronously; SETB leaves it running.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_cnt        <= '0;
            r_shift_done <= 1'b0;
        end else if (!bus.SE) begin
            r_cnt        <= '0;
            r_shift_done <= 1'b0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt        <= '0;
            r_shift_done <= 1'b1;
        end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_shift_done <= 1'b0;
        end
    end

    assign bus.Q          = w_q;
    assign bus.QN         = w_qn;
    assign bus.SO         = w_so;
    assign bus.SHIFT_DONE = r_shift_done;

endmodule
`default_nettype wire

// File: tb/tb_sdff_asr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdff_asr_bank
// Description : Self-checking bench for sdff_asr_bank. Two instances share
//               clock, async controls, SE/EN/D: dut1 (8 bits, 1 chain,
//               SET_MASK=0F) and dut2 (8 bits, 2 chains, SET_MASK=FF).
//               A behavioural model tracks both; literal checks pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdff_asr_bank;

    localparam logic [7:0] c_MASK [2] = '{8'h0F, 8'hFF};
    localparam int         c_LEN  [2] = '{8, 4};

    logic       CLK = 1'b0;
    logic       RSTB;
    logic       SETB;
    logic       se;
    logic       en;
    logic [7:0] d;
    logic       si1;
    logic [1:0] si2;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic [7:0] m_q    [2] = '{8'h00, 8'h00};
    int         m_run  [2] = '{0, 0};
    logic       m_done [2] = '{1'b0, 1'b0};

    sdff_asr_bank_if #(.WIDTH(8), .NUM_CHAINS(1)) bus1 ();
    sdff_asr_bank_if #(.WIDTH(8), .NUM_CHAINS(2)) bus2 ();

    assign bus1.SE = se;
    assign bus1.EN = en;
    assign bus1.D  = d;
    assign bus1.SI = si1;
    assign bus2.SE = se;
    assign bus2.EN = en;
    assign bus2.D  = d;
    assign bus2.SI = si2;

    sdff_asr_bank #(.WIDTH(8), .NUM_CHAINS(1), .SET_MASK(8'h0F)) u_dut1 (
        .CLK  (CLK),
        .RSTB (RSTB),
        .SETB (SETB),
        .bus  (bus1)
    );

    sdff_asr_bank #(.WIDTH(8), .NUM_CHAINS(2), .SET_MASK(8'hFF)) u_dut2 (
        .CLK  (CLK),
        .RSTB (RSTB),
        .SETB (SETB),
        .bus  (bus2)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    always @(negedge RSTB) begin
        for (int j = 0; j < 2; j++) begin
            m_q[j]    = 8'h00;
            m_run[j]  = 0;
            m_done[j] = 1'b0;
        end
    end

    always @(negedge SETB) begin
        if (RSTB === 1'b1) begin
            for (int j = 0; j < 2; j++) m_q[j] = m_q[j] | c_MASK[j];
        end
    end

    always @(posedge CLK) begin
        int         len;
        int         seg;
        int         nq;
        logic [1:0] siv;
        if (RSTB === 1'b1) begin
            for (int j = 0; j < 2; j++) begin
                len = c_LEN[j];
                siv = (j == 0) ? {1'b0, si1} : si2;
                if (se) begin
                    nq = 0;
                    for (int c = 0; c < 8 / len; c++) begin
                        seg = (int'(m_q[j]) >> (c * len)) & ((1 << len) - 1);
                        seg = ((seg << 1) | int'(siv[c])) & ((1 << len) - 1);
                        nq  = nq | (seg << (c * len));
                    end
                end else if (en) begin
                    nq = int'(d);
                end else begin
                    nq = int'(m_q[j]);
                end
                if (!SETB) nq = nq | int'(c_MASK[j]);
                m_q[j] = nq[7:0];
                if (se) begin
                    m_run[j]  = m_run[j] + 1;
                    m_done[j] = ((m_run[j] % len) == 0);
                end else begin
                    m_run[j]  = 0;
                    m_done[j] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_qn(input int j);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = (c_MASK[j][i] && !SETB) ? 1'b0 : (!RSTB ? 1'b1 : ~m_q[j][i]);
        return r;
    endfunction

    task automatic check_all();
        chk("dut1_q",    bus1.Q,                      m_q[0]);
        chk("dut1_qn",   bus1.QN,                     exp_qn(0));
        chk("dut1_so",   {7'b0, bus1.SO},             {7'b0, m_q[0][7]});
        chk("dut1_done", {7'b0, bus1.SHIFT_DONE},     {7'b0, m_done[0]});
        chk("dut2_q",    bus2.Q,                      m_q[1]);
        chk("dut2_qn",   bus2.QN,                     exp_qn(1));
        chk("dut2_so",   {6'b0, bus2.SO},             {6'b0, m_q[1][7], m_q[1][3]});
        chk("dut2_done", {7'b0, bus2.SHIFT_DONE},     {7'b0, m_done[1]});
    endtask

    always @(negedge CLK) check_all();

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] pat;
        int         kind;
        bit         long_pulse;

        RSTB = 1'b0; SETB = 1'b1; se = 1'b0; en = 1'b0;
        d = 8'h00; si1 = 1'b0; si2 = 2'b00;
        @(negedge CLK); #1;

        // reset state and functional load
        chk("rst_q",    bus1.Q,                  8'h00);
        chk("rst_qn",   bus1.QN,                 8'hFF);
        chk("rst_done", {7'b0, bus1.SHIFT_DONE}, 8'h00);
        RSTB = 1'b1; en = 1'b1; d = 8'hA5;
        tick();
        chk("load_q",  bus1.Q,  8'hA5);
        chk("load_qn", bus1.QN, 8'h5A);

        // single-chain shift of 1,0,1,1,0,0,1,0
        d = 8'h00;
        tick();
        en = 1'b0; se = 1'b1;
        pat = 8'b1011_0010;
        for (int k = 0; k < 8; k++) begin
            si1 = pat[7-k];
            tick();
            chk("shift1_done", {7'b0, bus1.SHIFT_DONE}, {7'b0, (k == 7)});
        end
        chk("shift1_q", bus1.Q, 8'b1011_0010);

        // two chains, continuous shift
        se = 1'b0; en = 1'b1; d = 8'h00; si1 = 1'b0;
        tick();
        en = 1'b0; se = 1'b1; si2 = 2'b10;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("shift2_done", {7'b0, bus2.SHIFT_DONE}, {7'b0, (k == 3 || k == 7)});
            if (k == 3) chk("shift2_q", bus2.Q, 8'hF0);
        end

        // masked async set, then reset on top, then release both
        se = 1'b0; en = 1'b0;
        SETB = 1'b0; #1;
        chk("set_q1",  bus1.Q,  8'h0F);
        chk("set_q2",  bus2.Q,  8'hFF);
        RSTB = 1'b0; #1;
        chk("both_q1",  bus1.Q,  8'h00);
        chk("both_qn1", bus1.QN, 8'hF0);
        RSTB = 1'b1; SETB = 1'b1; #1;
        chk("rel_q1",  bus1.Q,  8'h00);
        chk("rel_qn1", bus1.QN, 8'hFF);
        @(negedge CLK); #1;

        // reset mid-shift aborts the count
        se = 1'b1; si1 = 1'b1;
        repeat (3) tick();
        RSTB = 1'b0; #5;
        chk("abort_done", {7'b0, bus1.SHIFT_DONE}, 8'h00);
        RSTB = 1'b1;
        @(negedge CLK); #1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort_shift_done", {7'b0, bus1.SHIFT_DONE}, {7'b0, (k == 7)});
        end
        chk("abort_q", bus1.Q, 8'hFF);
        se = 1'b0; en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            tick();
            chk("hold_q", bus1.Q, 8'hFF);
        end

        // randomized phase
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(7) == 0) se = ~se;
            en  = 1'($urandom);
            d   = 8'($urandom);
            si1 = 1'($urandom);
            si2 = 2'($urandom);
            if ($urandom_range(15) == 0) begin
                kind       = int'($urandom_range(2));
                long_pulse = 1'($urandom);
                #1;
                if (kind != 1) RSTB = 1'b0;
                if (kind != 0) SETB = 1'b0;
                #1;
                check_all();
                if (long_pulse) #5; else #1;
                RSTB = 1'b1;
                SETB = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
